// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DROP = 2'd3
    } fetch_state_t;

    // Bit range of the branch/jump offset field within an instruction word.
    localparam int OFFSET_MSB = 25;
    localparam int OFFSET_LSB = 0;

    // Reset values; sliced down to the instantiated address/data widths.
    localparam logic [63:0] ADDR_RST = 64'h0;
    localparam logic [63:0] DATA_RST = 64'h0;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO with a registered head word; carries {pc, instr} pairs.
module fetch_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             clear,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
    logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
    logic [CNT_W-1:0] count_reg, count_next;
    logic [WIDTH-1:0] head_reg, head_next;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count_reg == CNT_W'(DEPTH));
    assign empty   = (count_reg == '0);
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);
    assign dout    = head_reg;

    always_comb begin
        rd_ptr_next = rd_ptr_reg;
        wr_ptr_next = wr_ptr_reg;
        count_next  = count_reg;
        head_next   = head_reg;
        if (clear) begin
            rd_ptr_next = '0;
            wr_ptr_next = '0;
            count_next  = '0;
        end else begin
            if (push_ok) begin
                wr_ptr_next = wr_ptr_reg + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr_next = rd_ptr_reg + PTR_W'(1);
            end
            if (push_ok && !pop_ok) begin
                count_next = count_reg + CNT_W'(1);
            end else if (!push_ok && pop_ok) begin
                count_next = count_reg - CNT_W'(1);
            end
            // Head tracks the next oldest entry; bypass din when it lands in that slot.
            if (count_next != '0) begin
                if (push_ok && (wr_ptr_reg == rd_ptr_next)) begin
                    head_next = din;
                end else begin
                    head_next = mem[rd_ptr_next];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_reg] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
            head_reg   <= '0;
        end else begin
            rd_ptr_reg <= rd_ptr_next;
            wr_ptr_reg <= wr_ptr_next;
            count_reg  <= count_next;
            head_reg   <= head_next;
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: single-outstanding instruction memory reads into a small buffer,
// PC advance handshake and branch flush handling.
module instr_fetch
    import fetch_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 32,
    parameter int FIFO_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] pc,
    output logic              pc_advance,
    input  logic              flush,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_rvalid,
    input  logic [DATA_W-1:0] imem_rdata,
    output logic              ir_valid,
    input  logic              ir_ready,
    output logic [DATA_W-1:0] ir,
    output logic [ADDR_W-1:0] ir_pc,
    output logic [25:0]       offset
);

    fetch_state_t      state_reg, state_next;
    logic [ADDR_W-1:0] req_pc_reg;
    logic              fifo_push;
    logic              fifo_pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [ADDR_W+DATA_W-1:0] fifo_din;
    logic [ADDR_W+DATA_W-1:0] fifo_dout;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: if (!fifo_full) state_next = REQ;
            REQ:  state_next = flush ? DROP : WAIT;
            WAIT: begin
                if (imem_rvalid) begin
                    state_next = IDLE;
                end else if (flush) begin
                    state_next = DROP;
                end
            end
            DROP: if (imem_rvalid) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg  <= IDLE;
            req_pc_reg <= ADDR_RST[ADDR_W-1:0];
        end else begin
            state_reg <= state_next;
            if (state_reg == REQ) begin
                req_pc_reg <= pc;
            end
        end
    end

    // Address goes straight from the PC so a post-flush target is picked up at once.
    assign imem_req   = (state_reg == REQ);
    assign imem_addr  = (state_reg == REQ) ? pc : ADDR_RST[ADDR_W-1:0];

    // The slot was reserved when leaving IDLE, so an accepted word always fits.
    assign fifo_push  = (state_reg == WAIT) && imem_rvalid && !flush;
    assign pc_advance = fifo_push;
    assign fifo_pop   = ir_valid && ir_ready;
    assign fifo_din   = {req_pc_reg, imem_rdata};

    fetch_fifo #(
        .WIDTH (ADDR_W + DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .clear (flush),
        .din   (fifo_din),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign ir_valid = !fifo_empty;
    assign ir_pc    = fifo_dout[ADDR_W+DATA_W-1:DATA_W];
    assign ir       = fifo_dout[DATA_W-1:0];
    assign offset   = ir[OFFSET_MSB:OFFSET_LSB];

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: memory/PC models, scoreboard of expected decode handoffs.
module tb_instr_fetch;

    localparam int DW = 32;
    localparam int AW = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [AW-1:0] pc;
    logic          pc_advance;
    logic          flush = 1'b0;
    logic          imem_req;
    logic [AW-1:0] imem_addr;
    logic          imem_rvalid = 1'b0;
    logic [DW-1:0] imem_rdata = '0;
    logic          ir_valid;
    logic          ir_ready = 1'b0;
    logic [DW-1:0] ir;
    logic [AW-1:0] ir_pc;
    logic [25:0]   offset;

    typedef struct packed {
        logic [AW-1:0] pc;
        logic [DW-1:0] word;
    } exp_t;

    exp_t          sb_q[$];
    exp_t          mon_e;
    int            checks = 0;
    int            passed = 0;

    // PC register model: base set by the bench (reset/branch), +4 per pc_advance.
    logic [AW-1:0] pc_base = '0;
    int            adv_total = 0;
    int            adv_mark = 0;
    int            mem_lat = 1;
    assign pc = pc_base + AW'((adv_total - adv_mark) * 4);

    instr_fetch #(.DATA_W(DW), .ADDR_W(AW), .FIFO_DEPTH(2)) dut (
        .clk         (clk),
        .rst         (rst),
        .pc          (pc),
        .pc_advance  (pc_advance),
        .flush       (flush),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .ir_valid    (ir_valid),
        .ir_ready    (ir_ready),
        .ir          (ir),
        .ir_pc       (ir_pc),
        .offset      (offset)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
        if (a == 32'h100) return 32'h0BFF_FFFC;
        return {a[15:0] ^ 16'hBEEF, a[15:0]};
    endfunction

    // Instruction memory: samples mid-cycle, drives 1 time unit after the edge.
    logic          req_s, adv_s, mem_pend;
    logic [AW-1:0] addr_s, mem_addr;
    int            mem_cnt;
    initial begin
        mem_pend = 1'b0;
        mem_cnt  = 0;
        mem_addr = '0;
        forever begin
            @(negedge clk);
            req_s  = imem_req;
            addr_s = imem_addr;
            adv_s  = pc_advance;
            @(posedge clk);
            #1;
            if (adv_s) adv_total++;
            imem_rvalid = 1'b0;
            if (!rst) begin
                mem_pend = 1'b0;
            end else begin
                if (mem_pend) begin
                    mem_cnt--;
                    if (mem_cnt == 0) begin
                        imem_rvalid = 1'b1;
                        imem_rdata  = mem_word(mem_addr);
                        mem_pend    = 1'b0;
                    end
                end
                if (req_s) begin
                    mem_addr = addr_s;
                    if (mem_lat <= 1) begin
                        imem_rvalid = 1'b1;
                        imem_rdata  = mem_word(addr_s);
                    end else begin
                        mem_pend = 1'b1;
                        mem_cnt  = mem_lat - 1;
                    end
                end
            end
        end
    end

    task automatic apply_reset(input logic [AW-1:0] start_pc, input int lat, input logic ready);
        @(posedge clk); #2;
        rst      = 1'b0;
        flush    = 1'b0;
        ir_ready = ready;
        mem_lat  = lat;
        pc_base  = start_pc;
        adv_mark = adv_total;
        sb_q.delete();
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b1;
    endtask

    task automatic wait_req(input logic [AW-1:0] a, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 60 && !ok; i++) begin
            @(negedge clk);
            if (imem_req && imem_addr == a) ok = 1'b1;
        end
    endtask

    task automatic wait_drain(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 80 && !ok; i++) begin
            @(negedge clk);
            if (sb_q.size() == 0) ok = 1'b1;
        end
        @(posedge clk); #2;
        ir_ready = 1'b0;
    endtask

    task automatic test_reset();
        #1 rst = 1'b0;
        pc_base = 32'h1234;
        repeat (2) @(negedge clk);
        checks += 6;
        if (imem_req !== 1'b0) $display("FAIL reset_imem_req: got %0b want 0", imem_req); else passed++;
        if (imem_addr !== '0) $display("FAIL reset_imem_addr: got %h want 0", imem_addr); else passed++;
        if (pc_advance !== 1'b0) $display("FAIL reset_pc_advance: got %0b want 0", pc_advance); else passed++;
        if (ir_valid !== 1'b0) $display("FAIL reset_ir_valid: got %0b want 0", ir_valid); else passed++;
        if (ir !== '0) $display("FAIL reset_ir: got %h want 0", ir); else passed++;
        if (ir_pc !== '0) $display("FAIL reset_ir_pc: got %h want 0", ir_pc); else passed++;
    endtask

    task automatic test_stream();
        bit ok;
        logic [AW-1:0] a;
        apply_reset(32'h0, 1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            a = AW'(i * 4);
            sb_q.push_back('{pc: a, word: mem_word(a)});
        end
        for (int i = 0; i < 3; i++) begin
            a = AW'(i * 4);
            wait_req(a, ok);
            checks++;
            if (!ok) $display("FAIL stream_req: no imem_req for addr %h within bound", a); else passed++;
            @(negedge clk);
            checks++;
            if (pc_advance !== 1'b1) $display("FAIL stream_pc_advance: got %0b want 1 (addr %h)", pc_advance, a); else passed++;
            @(negedge clk);
            checks++;
            if (ir_valid !== 1'b1) $display("FAIL stream_ir_valid: got %0b want 1 (addr %h)", ir_valid, a); else passed++;
        end
        wait_drain(ok);
        checks++;
        if (!ok) $display("FAIL stream_drain: %0d words left, want 0", sb_q.size()); else passed++;
    endtask

    task automatic test_backpressure();
        bit ok;
        int n_req = 0;
        int n_adv = 0;
        apply_reset(32'h0, 1, 1'b0);
        sb_q.push_back('{pc: 32'h0, word: mem_word(32'h0)});
        sb_q.push_back('{pc: 32'h4, word: mem_word(32'h4)});
        sb_q.push_back('{pc: 32'h8, word: mem_word(32'h8)});
        repeat (30) begin
            @(negedge clk);
            if (imem_req) n_req++;
            if (pc_advance) n_adv++;
        end
        checks += 4;
        if (n_req != 2) $display("FAIL bp_req_count: got %0d want 2", n_req); else passed++;
        if (n_adv != 2) $display("FAIL bp_adv_count: got %0d want 2", n_adv); else passed++;
        if (ir_valid !== 1'b1) $display("FAIL bp_ir_valid: got %0b want 1", ir_valid); else passed++;
        if (ir_pc !== 32'h0) $display("FAIL bp_head_pc: got %h want 0", ir_pc); else passed++;
        @(posedge clk); #2;
        ir_ready = 1'b1;
        wait_drain(ok);
        checks++;
        if (!ok) $display("FAIL bp_drain: %0d words left, want 0", sb_q.size()); else passed++;
    endtask

    task automatic test_flush_drop();
        bit ok;
        int n_adv = 0;
        apply_reset(32'h0, 4, 1'b1);
        sb_q.push_back('{pc: 32'h0, word: mem_word(32'h0)});
        wait_drain(ok);
        checks++;
        if (!ok) $display("FAIL drop_first_word: %0d words left, want 0", sb_q.size()); else passed++;
        wait_req(32'h8, ok);
        checks++;
        if (!ok) $display("FAIL drop_req8: no imem_req for addr 8 within bound"); else passed++;
        @(posedge clk); #2;
        @(negedge clk);
        checks++;
        if (ir_valid !== 1'b1) $display("FAIL drop_pre_valid: got %0b want 1", ir_valid); else passed++;
        @(posedge clk); #2;
        flush    = 1'b1;
        pc_base  = 32'h40;
        adv_mark = adv_total;
        @(posedge clk); #2;
        flush = 1'b0;
        @(negedge clk);
        checks++;
        if (ir_valid !== 1'b0) $display("FAIL drop_fifo_cleared: ir_valid got %0b want 0", ir_valid); else passed++;
        ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            if (pc_advance) n_adv++;
            if (imem_req) ok = 1'b1; else @(negedge clk);
        end
        checks += 3;
        if (!ok) $display("FAIL drop_req_after: no imem_req within bound"); else passed++;
        if (imem_addr !== 32'h40) $display("FAIL drop_new_addr: got %h want 00000040", imem_addr); else passed++;
        if (n_adv != 0) $display("FAIL drop_no_advance: got %0d pulses want 0", n_adv); else passed++;
        sb_q.push_back('{pc: 32'h40, word: mem_word(32'h40)});
        @(posedge clk); #2;
        ir_ready = 1'b1;
        wait_drain(ok);
        checks++;
        if (!ok) $display("FAIL drop_drain: %0d words left, want 0", sb_q.size()); else passed++;
    endtask

    task automatic test_flush_rvalid_pop();
        bit ok;
        apply_reset(32'h0, 1, 1'b0);
        wait_req(32'h4, ok);
        checks += 2;
        if (!ok) $display("FAIL frp_req4: no imem_req for addr 4 within bound"); else passed++;
        if (ir_valid !== 1'b1) $display("FAIL frp_pre_valid: got %0b want 1", ir_valid); else passed++;
        @(posedge clk); #2;
        flush    = 1'b1;
        ir_ready = 1'b1;
        pc_base  = 32'h80;
        adv_mark = adv_total;
        @(negedge clk);
        checks++;
        if (pc_advance !== 1'b0) $display("FAIL frp_no_advance: got %0b want 0", pc_advance); else passed++;
        @(posedge clk); #2;
        flush    = 1'b0;
        ir_ready = 1'b0;
        @(negedge clk);
        checks += 2;
        if (ir_valid !== 1'b0) $display("FAIL frp_ir_valid: got %0b want 0", ir_valid); else passed++;
        if (imem_req !== 1'b0) $display("FAIL frp_idle_req: got %0b want 0", imem_req); else passed++;
        @(negedge clk);
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h80)
            $display("FAIL frp_next_req: got req=%0b addr=%h want req=1 addr=00000080", imem_req, imem_addr);
        else passed++;
    endtask

    task automatic test_async_reset();
        bit ok;
        int n_adv = 0;
        int n_rv = 0;
        apply_reset(32'h200, 1, 1'b0);
        wait_req(32'h204, ok);
        checks++;
        if (!ok) $display("FAIL ar_req: no imem_req for addr 204 within bound"); else passed++;
        @(posedge clk); #3;
        checks += 2;
        if (pc_advance !== 1'b1) $display("FAIL ar_pre_advance: got %0b want 1", pc_advance); else passed++;
        if (ir_valid !== 1'b1) $display("FAIL ar_pre_valid: got %0b want 1", ir_valid); else passed++;
        rst = 1'b0;
        #1;
        checks += 6;
        if (imem_req !== 1'b0) $display("FAIL ar_imem_req: got %0b want 0", imem_req); else passed++;
        if (imem_addr !== '0) $display("FAIL ar_imem_addr: got %h want 0", imem_addr); else passed++;
        if (pc_advance !== 1'b0) $display("FAIL ar_pc_advance: got %0b want 0", pc_advance); else passed++;
        if (ir_valid !== 1'b0) $display("FAIL ar_ir_valid: got %0b want 0", ir_valid); else passed++;
        if (ir !== '0) $display("FAIL ar_ir: got %h want 0", ir); else passed++;
        if (ir_pc !== '0) $display("FAIL ar_ir_pc: got %h want 0", ir_pc); else passed++;
        repeat (2) @(posedge clk);
        #2;
        pc_base  = 32'h300;
        adv_mark = adv_total;
        rst      = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            if (pc_advance) n_adv++;
            if (imem_rvalid) n_rv++;
            if (imem_req) ok = 1'b1;
        end
        checks += 4;
        if (!ok) $display("FAIL ar_restart: no imem_req within bound"); else passed++;
        if (imem_addr !== 32'h300) $display("FAIL ar_restart_addr: got %h want 00000300", imem_addr); else passed++;
        if (n_adv != 0) $display("FAIL ar_no_advance: got %0d pulses want 0", n_adv); else passed++;
        if (n_rv != 0) $display("FAIL ar_stale_rvalid: got %0d want 0", n_rv); else passed++;
        sb_q.push_back('{pc: 32'h300, word: mem_word(32'h300)});
        @(posedge clk); #2;
        ir_ready = 1'b1;
        wait_drain(ok);
        checks++;
        if (!ok) $display("FAIL ar_drain: %0d words left, want 0", sb_q.size()); else passed++;
    endtask

    task automatic test_offset();
        bit ok = 1'b0;
        apply_reset(32'h100, 1, 1'b0);
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            if (ir_valid) ok = 1'b1;
        end
        checks += 4;
        if (!ok) $display("FAIL off_valid: ir_valid never rose within bound"); else passed++;
        if (offset !== 26'h3FF_FFFC) $display("FAIL off_offset: got %h want 3fffffc", offset); else passed++;
        if (ir !== 32'h0BFF_FFFC) $display("FAIL off_ir: got %h want 0bfffffc", ir); else passed++;
        if (ir_pc !== 32'h100) $display("FAIL off_ir_pc: got %h want 00000100", ir_pc); else passed++;
    endtask

    initial begin
        fork
            forever begin
                @(negedge clk);
                if (rst && ir_valid && ir_ready && !flush) begin
                    checks++;
                    if (sb_q.size() == 0) begin
                        $display("FAIL sb_unexpected: got pc=%h ir=%h, want no word", ir_pc, ir);
                    end else begin
                        mon_e = sb_q.pop_front();
                        if (ir_pc !== mon_e.pc || ir !== mon_e.word)
                            $display("FAIL sb_word: got pc=%h ir=%h want pc=%h ir=%h", ir_pc, ir, mon_e.pc, mon_e.word);
                        else begin
                            passed++;
                            $display("txn decode pc=%h ir=%h", ir_pc, ir);
                        end
                    end
                end
            end
        join_none
        test_reset();
        test_stream();
        test_backpressure();
        test_flush_drop();
        test_flush_rvalid_pop();
        test_async_reset();
        test_offset();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
